// File: rtl/accum_chain.sv
// NUM_CH step counters feeding one accumulator, with optional clamping, a sticky
// overflow flag and a valid/ready snapshot port for sampling ACC.
module accum_chain #(
  parameter int unsigned     WIDTH  = 32,
  parameter int unsigned     NUM_CH = 2,
  parameter int unsigned     STEP   = 2,
  parameter longint unsigned INC    = 1
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    EN,
  input  logic                    CLR,
  input  logic                    SAT_MODE,
  output logic [NUM_CH*WIDTH-1:0] CH_OUT,
  output logic [WIDTH-1:0]        ACC,
  output logic                    OVF,
  input  logic                    SNAP_REQ,
  output logic                    SNAP_VALID,
  input  logic                    SNAP_READY,
  output logic [WIDTH-1:0]        SNAP_DATA
);

  // Wide enough for ACC + INC + NUM_CH channels, each at most 2^WIDTH-1.
  localparam int unsigned      SUM_W   = WIDTH + $clog2(NUM_CH + 2);
  localparam logic [WIDTH-1:0] ACC_MAX = '1;

  typedef enum logic {S_IDLE, S_HELD} snap_state_t;

  logic [WIDTH-1:0] r_ch [NUM_CH];
  logic [WIDTH-1:0] r_acc;
  logic             r_ovf;
  logic [WIDTH-1:0] r_snap_data;
  snap_state_t      r_state;

  logic [SUM_W-1:0] w_sum;
  snap_state_t      w_state_nxt;
  logic             w_snap_cap;

  function automatic logic [WIDTH-1:0] ch_step(input int unsigned idx);
    return WIDTH'(longint'(STEP) * longint'(idx + 1));
  endfunction

  function automatic logic sum_overflows(input logic [SUM_W-1:0] s);
    return |s[SUM_W-1:WIDTH];
  endfunction

  function automatic logic [WIDTH-1:0] limit_acc(input logic [SUM_W-1:0] s,
                                                 input logic sat);
    if (sat && sum_overflows(s))
      return ACC_MAX;
    else
      return s[WIDTH-1:0];
  endfunction

  // Channel counters: wrap naturally, multiples of their step are preserved.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (RST || CLR)
        r_ch[i] <= '0;
      else if (EN)
        r_ch[i] <= r_ch[i] + ch_step(i);
    end
  end

  always_comb begin
    CH_OUT = '0;
    for (int i = 0; i < NUM_CH; i++)
      CH_OUT[i*WIDTH +: WIDTH] = r_ch[i];
  end

  // Full-precision sum over registered channel values (one cycle of lag).
  always_comb begin
    w_sum = SUM_W'(r_acc) + SUM_W'(INC);
    for (int i = 0; i < NUM_CH; i++)
      w_sum = w_sum + SUM_W'(r_ch[i]);
  end

  always_ff @(posedge CLK) begin
    if (RST || CLR) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (EN) begin
      r_acc <= limit_acc(w_sum, SAT_MODE);
      if (sum_overflows(w_sum))
        r_ovf <= 1'b1;
    end
  end

  assign ACC = r_acc;
  assign OVF = r_ovf;

  // Snapshot FSM: CLR and EN deliberately have no influence here.
  always_ff @(posedge CLK) begin
    if (RST)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (SNAP_REQ)   w_state_nxt = S_HELD;
      S_HELD:  if (SNAP_READY) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_snap_cap = (r_state == S_IDLE) && SNAP_REQ;
    SNAP_VALID = (r_state == S_HELD);
  end

  always_ff @(posedge CLK) begin
    if (RST)
      r_snap_data <= '0;
    else if (w_snap_cap)
      r_snap_data <= r_acc;
  end

  assign SNAP_DATA = r_snap_data;

`ifndef SYNTHESIS
  always @(posedge CLK) begin
    for (int i = 0; i < NUM_CH; i++)
      a_ch_aligned: assert ((r_ch[i] & (ch_step(i) - 1'b1)) == '0)
        else $error("channel %0d lost step alignment: %0d", i, r_ch[i]);
  end

  a_snap_stable: assert property (@(posedge CLK) disable iff (RST)
    (SNAP_VALID && !SNAP_READY) |=> $stable(SNAP_DATA));

  a_sat_monotonic: assert property (@(posedge CLK) disable iff (RST)
    (SAT_MODE && !CLR) |=> (ACC >= $past(ACC)));
`endif

endmodule

// File: tb/tb_accum_chain.sv
// Directed bench: a default-parameter instance driven from a vector table and a
// WIDTH=8 instance driven by short hand-written overflow/wrap sequences.
module tb_accum_chain;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_err    = 0;

  // Default instance (WIDTH=32, NUM_CH=2, STEP=2, INC=1)
  logic        d_rst, d_en, d_clr, d_sat, d_req, d_rdy;
  logic [63:0] d_ch_out;
  logic [31:0] d_acc, d_sd;
  logic        d_ovf, d_sv;

  accum_chain u_def (
    .CLK(CLK), .RST(d_rst), .EN(d_en), .CLR(d_clr), .SAT_MODE(d_sat),
    .CH_OUT(d_ch_out), .ACC(d_acc), .OVF(d_ovf),
    .SNAP_REQ(d_req), .SNAP_VALID(d_sv), .SNAP_READY(d_rdy), .SNAP_DATA(d_sd)
  );

  // Narrow instance for overflow, saturation and channel wrap
  logic        e_rst, e_en, e_clr, e_sat, e_req, e_rdy;
  logic [15:0] e_ch_out;
  logic [7:0]  e_acc, e_sd;
  logic        e_ovf, e_sv;

  accum_chain #(.WIDTH(8)) u_w8 (
    .CLK(CLK), .RST(e_rst), .EN(e_en), .CLR(e_clr), .SAT_MODE(e_sat),
    .CH_OUT(e_ch_out), .ACC(e_acc), .OVF(e_ovf),
    .SNAP_REQ(e_req), .SNAP_VALID(e_sv), .SNAP_READY(e_rdy), .SNAP_DATA(e_sd)
  );

  typedef struct {
    logic rst, en, clr, req, rdy;
    int   acc, ch0, ch1;
    logic ovf, sv;
    int   sd;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic e_run(input int n);
    e_en = 1'b1;
    repeat (n) tick();
  endtask

  initial begin
    //           rst en clr req rdy  acc ch0 ch1 ovf sv  sd
    vecs[0]  = '{0, 1, 0, 0, 0,   1,   2,  4, 0, 0,   0};
    vecs[1]  = '{0, 1, 0, 0, 0,   8,   4,  8, 0, 0,   0};
    vecs[2]  = '{0, 1, 0, 0, 0,  21,   6, 12, 0, 0,   0};
    vecs[3]  = '{0, 1, 0, 1, 0,  40,   8, 16, 0, 1,  21};
    vecs[4]  = '{0, 1, 0, 0, 0,  65,  10, 20, 0, 1,  21};
    vecs[5]  = '{0, 1, 0, 0, 0,  96,  12, 24, 0, 1,  21};
    vecs[6]  = '{0, 1, 0, 0, 0, 133,  14, 28, 0, 1,  21};
    vecs[7]  = '{0, 1, 0, 1, 1, 176,  16, 32, 0, 0,  21};
    vecs[8]  = '{0, 0, 0, 0, 0, 176,  16, 32, 0, 0,  21};
    vecs[9]  = '{0, 1, 0, 1, 0, 225,  18, 36, 0, 1, 176};
    vecs[10] = '{0, 1, 1, 0, 0,   0,   0,  0, 0, 1, 176};
    vecs[11] = '{0, 1, 0, 0, 0,   1,   2,  4, 0, 1, 176};
    vecs[12] = '{0, 0, 0, 0, 0,   1,   2,  4, 0, 1, 176};
    vecs[13] = '{0, 0, 0, 0, 0,   1,   2,  4, 0, 1, 176};
    vecs[14] = '{0, 1, 0, 0, 0,   8,   4,  8, 0, 1, 176};
    vecs[15] = '{1, 1, 0, 0, 0,   0,   0,  0, 0, 0,   0};
    vecs[16] = '{0, 1, 0, 0, 1,   1,   2,  4, 0, 0,   0};

    d_rst = 1'b1; d_en = 1'b0; d_clr = 1'b0; d_sat = 1'b0; d_req = 1'b0; d_rdy = 1'b0;
    e_rst = 1'b1; e_en = 1'b0; e_clr = 1'b0; e_sat = 1'b0; e_req = 1'b0; e_rdy = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    d_rst = 1'b0;
    e_rst = 1'b0;

    chk("reset acc",  64'(d_acc), 64'd0);
    chk("reset ch",   64'(d_ch_out), 64'd0);
    chk("reset ovf",  64'(d_ovf), 64'd0);
    chk("reset sv",   64'(d_sv), 64'd0);
    chk("reset sd",   64'(d_sd), 64'd0);

    for (int i = 0; i < NV; i++) begin
      d_rst = vecs[i].rst; d_en = vecs[i].en; d_clr = vecs[i].clr;
      d_req = vecs[i].req; d_rdy = vecs[i].rdy;
      tick();
      chk($sformatf("row%0d acc", i), 64'(d_acc), 64'(vecs[i].acc));
      chk($sformatf("row%0d ch0", i), 64'(d_ch_out[31:0]), 64'(vecs[i].ch0));
      chk($sformatf("row%0d ch1", i), 64'(d_ch_out[63:32]), 64'(vecs[i].ch1));
      chk($sformatf("row%0d ovf", i), 64'(d_ovf), 64'(vecs[i].ovf));
      chk($sformatf("row%0d sv", i),  64'(d_sv), 64'(vecs[i].sv));
      chk($sformatf("row%0d sd", i),  64'(d_sd), 64'(vecs[i].sd));
    end

    // WIDTH=8 clamping: 225, then 280 clamps to 255 with OVF, then stays
    e_sat = 1'b1;
    e_run(9);
    chk("w8 sat k9 acc", 64'(e_acc), 64'd225);
    chk("w8 sat k9 ovf", 64'(e_ovf), 64'd0);
    e_run(1);
    chk("w8 sat k10 acc", 64'(e_acc), 64'd255);
    chk("w8 sat k10 ovf", 64'(e_ovf), 64'd1);
    e_run(1);
    chk("w8 sat k11 acc", 64'(e_acc), 64'd255);
    chk("w8 sat k11 ovf", 64'(e_ovf), 64'd1);
    chk("w8 sat k11 ch0", 64'(e_ch_out[7:0]), 64'd22);
    chk("w8 sat k11 ch1", 64'(e_ch_out[15:8]), 64'd44);

    // Same run wrapping: 280 mod 256 = 24, then 24+1+20+40 = 85
    e_en = 1'b0; e_sat = 1'b0; e_rst = 1'b1;
    tick();
    e_rst = 1'b0;
    e_run(10);
    chk("w8 wrap k10 acc", 64'(e_acc), 64'd24);
    chk("w8 wrap k10 ovf", 64'(e_ovf), 64'd1);
    e_run(1);
    chk("w8 wrap k11 acc", 64'(e_acc), 64'd85);
    chk("w8 wrap k11 ovf", 64'(e_ovf), 64'd1);

    e_en = 1'b0; e_clr = 1'b1;
    tick();
    e_clr = 1'b0;
    chk("w8 clr acc", 64'(e_acc), 64'd0);
    chk("w8 clr ch",  64'(e_ch_out), 64'd0);
    chk("w8 clr ovf", 64'(e_ovf), 64'd0);

    // Channel wrap: after 64 steps ch0 = 128, ch1 = 256 mod 256 = 0
    e_run(64);
    e_en = 1'b0;
    chk("w8 wrap ch0", 64'(e_ch_out[7:0]), 64'd128);
    chk("w8 wrap ch1", 64'(e_ch_out[15:8]), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
